// File: rtl/cp0_timer_irq_if.sv
`default_nettype none
// ============================================================================
//  Module      : cp0_timer_irq_if
//  Description : Pipeline-to-CP0 signal bundle. The M stage drives mfc0/mtc0
//                requests, exception/ERET status and the raw interrupt lines.
//                CP0 returns the take decision, EPC, timer flag and read data.
//                Ports: rd_addr, wr_addr, wr_data, we, pc, bd, exc_valid,
//                exc_code_in, bad_vaddr_in, eret, hwint (pipeline -> CP0);
//                exc_take, epc, timer_irq, rd_data (CP0 -> pipeline).
//  Revision    : 1.0 - initial release
// ============================================================================
interface cp0_timer_irq_if #(
    parameter int NUM_HWINT = 6
);
    logic [4:0]           rd_addr;
    logic [4:0]           wr_addr;
    logic [31:0]          wr_data;
    logic                 we;
    logic [31:0]          pc;
    logic                 bd;
    logic                 exc_valid;
    logic [4:0]           exc_code_in;
    logic [31:0]          bad_vaddr_in;
    logic                 eret;
    logic [NUM_HWINT-1:0] hwint;
    logic                 exc_take;
    logic [31:0]          epc;
    logic                 timer_irq;
    logic [31:0]          rd_data;

    // Pipeline side
    modport master (
        output rd_addr, wr_addr, wr_data, we, pc, bd, exc_valid,
               exc_code_in, bad_vaddr_in, eret, hwint,
        input  exc_take, epc, timer_irq, rd_data
    );

    // CP0 side
    modport slave (
        input  rd_addr, wr_addr, wr_data, we, pc, bd, exc_valid,
               exc_code_in, bad_vaddr_in, eret, hwint,
        output exc_take, epc, timer_irq, rd_data
    );
endinterface
`default_nettype wire

// File: rtl/cp0_timer_irq.sv
`default_nettype none
// ============================================================================
//  Module      : cp0_timer_irq
//  Description : Coprocessor 0 for the 5-stage MIPS core. Holds SR, Cause,
//                EPC, PrID, BadVAddr, Count and Compare; decides exception
//                and interrupt entry for the M-stage instruction.
//  Ports       : clk, reset (synchronous, active-high)
//                bus (cp0_timer_irq_if.slave):
//                  in : rd_addr, wr_addr, wr_data, we, pc, bd, exc_valid,
//                       exc_code_in, bad_vaddr_in, eret, hwint
//                  out: exc_take (comb), epc (reg), timer_irq (reg),
//                       rd_data (comb)
//  Revision    : 1.0 - initial release
// ============================================================================
module cp0_timer_irq #(
    parameter int          NUM_HWINT = 6,            // 1..6, line i -> bit 10+i
    parameter bit          TIMER_EN  = 1'b1,
    parameter logic [31:0] PRID_VAL  = 32'h0000_5043
) (
    input  wire logic         clk,
    input  wire logic         reset,
    cp0_timer_irq_if.slave    bus
);

    localparam logic [4:0] c_reg_badvaddr = 5'd8;
    localparam logic [4:0] c_reg_count    = 5'd9;
    localparam logic [4:0] c_reg_compare  = 5'd11;
    localparam logic [4:0] c_reg_sr       = 5'd12;
    localparam logic [4:0] c_reg_cause    = 5'd13;
    localparam logic [4:0] c_reg_epc      = 5'd14;
    localparam logic [4:0] c_reg_prid     = 5'd15;

    localparam logic [4:0] c_exc_adel     = 5'd4;
    localparam logic [4:0] c_exc_ades     = 5'd5;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [NUM_HWINT-1:0] im_q,       im_d;
    logic                 exl_q,      exl_d;
    logic                 ie_q,       ie_d;
    logic                 bd_q,       bd_d;
    logic                 ti_q,       ti_d;
    logic [NUM_HWINT-1:0] ip_q,       ip_d;
    logic [4:0]           exc_code_q, exc_code_d;
    logic [31:0]          epc_q,      epc_d;
    logic [31:0]          badvaddr_q, badvaddr_d;
    logic [31:0]          count_q,    count_d;
    logic [31:0]          compare_q,  compare_d;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic [NUM_HWINT-1:0] hwint_w;
    logic [NUM_HWINT-1:0] pend_w;
    logic                 int_pend_w;
    logic                 exc_take_w;
    logic [4:0]           take_code_w;
    logic [5:0]           im_ext_w;
    logic [5:0]           ip_ext_w;
    logic [31:0]          rd_data_w;

    assign hwint_w = bus.hwint;

    // The timer request shares the highest implemented interrupt line.
    generate
        if (TIMER_EN) begin : g_timer_line
            always_comb begin
                pend_w                = hwint_w;
                pend_w[NUM_HWINT-1]   = hwint_w[NUM_HWINT-1] | ti_q;
            end
        end else begin : g_no_timer_line
            always_comb begin
                pend_w = hwint_w;
            end
        end
    endgenerate

    assign int_pend_w  = ie_q & ~exl_q & (|(pend_w & im_q));
    assign exc_take_w  = int_pend_w | bus.exc_valid;
    // Interrupts outrank a synchronous exception in the same cycle.
    assign take_code_w = int_pend_w ? 5'd0 : bus.exc_code_in;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        im_d       = im_q;
        exl_d      = exl_q;
        ie_d       = ie_q;
        bd_d       = bd_q;
        ti_d       = ti_q;
        exc_code_d = exc_code_q;
        epc_d      = epc_q;
        badvaddr_d = badvaddr_q;
        compare_d  = compare_q;
        ip_d       = pend_w;

        if (TIMER_EN) begin
            count_d = count_q + 32'd1;
            if (count_q == compare_q) begin
                ti_d = 1'b1;
            end
        end else begin
            count_d = 32'd0;
            ti_d    = 1'b0;
        end

        if (exc_take_w) begin
            // A nested entry keeps the original return point.
            if (!exl_q) begin
                epc_d = bus.bd ? (bus.pc - 32'd4) : bus.pc;
                bd_d  = bus.bd;
            end
            exl_d      = 1'b1;
            exc_code_d = take_code_w;
            if ((take_code_w == c_exc_adel) || (take_code_w == c_exc_ades)) begin
                badvaddr_d = bus.bad_vaddr_in;
            end
        end else begin
            if (bus.we) begin
                case (bus.wr_addr)
                    c_reg_count: begin
                        if (TIMER_EN) begin
                            count_d = bus.wr_data;
                        end
                    end
                    c_reg_compare: begin
                        if (TIMER_EN) begin
                            compare_d = bus.wr_data;
                            ti_d      = 1'b0;
                        end
                    end
                    c_reg_sr: begin
                        im_d  = bus.wr_data[10 +: NUM_HWINT];
                        exl_d = bus.wr_data[1];
                        ie_d  = bus.wr_data[0];
                    end
                    c_reg_epc: begin
                        epc_d = bus.wr_data;
                    end
                    default: begin
                    end
                endcase
            end
            if (bus.eret) begin
                exl_d = 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            im_q       <= '1;
            exl_q      <= 1'b0;
            ie_q       <= 1'b1;
            bd_q       <= 1'b0;
            ti_q       <= 1'b0;
            ip_q       <= '0;
            exc_code_q <= 5'd0;
            epc_q      <= 32'd0;
            badvaddr_q <= 32'd0;
            count_q    <= 32'd0;
            compare_q  <= 32'd0;
        end else begin
            im_q       <= im_d;
            exl_q      <= exl_d;
            ie_q       <= ie_d;
            bd_q       <= bd_d;
            ti_q       <= ti_d;
            ip_q       <= ip_d;
            exc_code_q <= exc_code_d;
            epc_q      <= epc_d;
            badvaddr_q <= badvaddr_d;
            count_q    <= count_d;
            compare_q  <= compare_d;
        end
    end

    // ------------------------------------------------------------------
    // mfc0 read mux
    // ------------------------------------------------------------------
    always_comb begin
        im_ext_w                  = 6'd0;
        ip_ext_w                  = 6'd0;
        im_ext_w[NUM_HWINT-1:0]   = im_q;
        ip_ext_w[NUM_HWINT-1:0]   = ip_q;
    end

    always_comb begin
        rd_data_w = 32'd0;
        case (bus.rd_addr)
            c_reg_badvaddr: rd_data_w = badvaddr_q;
            c_reg_count:    rd_data_w = count_q;
            c_reg_compare:  rd_data_w = compare_q;
            c_reg_sr:       rd_data_w = {16'd0, im_ext_w, 8'd0, exl_q, ie_q};
            c_reg_cause:    rd_data_w = {bd_q, ti_q, 14'd0, ip_ext_w, 3'd0,
                                         exc_code_q, 2'd0};
            c_reg_epc:      rd_data_w = epc_q;
            c_reg_prid:     rd_data_w = PRID_VAL;
            default:        rd_data_w = 32'd0;
        endcase
    end

    assign bus.exc_take  = exc_take_w;
    assign bus.epc       = epc_q;
    assign bus.timer_irq = ti_q;
    assign bus.rd_data   = rd_data_w;

endmodule
`default_nettype wire

// File: tb/tb_cp0_timer_irq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cp0_timer_irq
//  Description : Self-checking bench for cp0_timer_irq (NUM_HWINT = 6,
//                timer present). A vector table covers single-cycle CP0
//                behaviour; hand sequences cover the timer and mid-run reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cp0_timer_irq;

    localparam int NV = 20;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    cp0_timer_irq_if #(.NUM_HWINT(6)) bus ();

    cp0_timer_irq #(
        .NUM_HWINT (6),
        .TIMER_EN  (1'b1),
        .PRID_VAL  (32'h0000_5043)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic        we;
        logic [4:0]  wr_addr;
        logic [31:0] wr_data;
        logic [31:0] pc;
        logic        bd;
        logic        exc_valid;
        logic [4:0]  code;
        logic [31:0] badv;
        logic        eret;
        logic [5:0]  hwint;
        logic        exp_take;
        logic [4:0]  chk_addr;
        logic [31:0] exp_rd;
        logic [31:0] exp_epc;
    } vec_t;

    vec_t vecs [NV];

    function automatic vec_t mk(
        input logic we, input logic [4:0] wa, input logic [31:0] wd,
        input logic [31:0] pc, input logic bd, input logic ev,
        input logic [4:0] code, input logic [31:0] badv, input logic eret,
        input logic [5:0] hw, input logic take, input logic [4:0] ca,
        input logic [31:0] rd, input logic [31:0] epc);
        vec_t v;
        v.we = we; v.wr_addr = wa; v.wr_data = wd; v.pc = pc; v.bd = bd;
        v.exc_valid = ev; v.code = code; v.badv = badv; v.eret = eret;
        v.hwint = hw; v.exp_take = take; v.chk_addr = ca; v.exp_rd = rd;
        v.exp_epc = epc;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.we = 1'b0; bus.wr_addr = 5'd0; bus.wr_data = 32'd0;
        bus.pc = 32'd0; bus.bd = 1'b0; bus.exc_valid = 1'b0;
        bus.exc_code_in = 5'd0; bus.bad_vaddr_in = 32'd0;
        bus.eret = 1'b0; bus.hwint = 6'd0;
    endtask

    task automatic read_chk(input string nm, input logic [4:0] a, input logic [31:0] exp);
        bus.rd_addr = a;
        #1;
        chk(nm, bus.rd_data, exp);
    endtask

    // One clock of mtc0 (or idle when we = 0); ends 1 time unit after the edge.
    task automatic cycle_wr(input logic we, input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.we = we; bus.wr_addr = a; bus.wr_data = d;
        @(posedge clk); #1;
        clear_inputs();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        clear_inputs();
        bus.rd_addr = 5'd0;
        reset = 1'b1;

        //            we wa     wd            pc            bd ev code   badv          er hw     tk ca     rd            epc
        vecs[0]  = mk(1, 5'd11, 32'hFFFF0000, 32'h0,        0, 0, 5'd0,  32'h0,        0, 6'h00, 0, 5'd13, 32'h00000000, 32'h00000000);
        vecs[1]  = mk(0, 5'd0,  32'h0,        32'h3010,     0, 0, 5'd0,  32'h0,        0, 6'h04, 1, 5'd13, 32'h00001000, 32'h00003010);
        vecs[2]  = mk(0, 5'd0,  32'h0,        32'h3014,     0, 0, 5'd0,  32'h0,        0, 6'h04, 0, 5'd12, 32'h0000FC03, 32'h00003010);
        vecs[3]  = mk(0, 5'd0,  32'h0,        32'h0,        0, 0, 5'd0,  32'h0,        1, 6'h00, 0, 5'd12, 32'h0000FC01, 32'h00003010);
        vecs[4]  = mk(0, 5'd0,  32'h0,        32'h3020,     1, 1, 5'd4,  32'h00001003, 0, 6'h00, 1, 5'd13, 32'h80000010, 32'h0000301C);
        vecs[5]  = mk(0, 5'd0,  32'h0,        32'h5000,     0, 1, 5'd10, 32'h0000AAAA, 0, 6'h00, 1, 5'd13, 32'h80000028, 32'h0000301C);
        vecs[6]  = mk(0, 5'd0,  32'h0,        32'h0,        0, 0, 5'd0,  32'h0,        0, 6'h00, 0, 5'd8,  32'h00001003, 32'h0000301C);
        vecs[7]  = mk(0, 5'd0,  32'h0,        32'h0,        0, 0, 5'd0,  32'h0,        1, 6'h00, 0, 5'd12, 32'h0000FC01, 32'h0000301C);
        vecs[8]  = mk(0, 5'd0,  32'h0,        32'h4000,     0, 1, 5'd12, 32'h0000DEAD, 0, 6'h01, 1, 5'd13, 32'h00000400, 32'h00004000);
        vecs[9]  = mk(0, 5'd0,  32'h0,        32'h0,        0, 0, 5'd0,  32'h0,        1, 6'h00, 0, 5'd8,  32'h00001003, 32'h00004000);
        vecs[10] = mk(1, 5'd12, 32'h00000000, 32'h4100,     0, 1, 5'd12, 32'h0,        0, 6'h00, 1, 5'd12, 32'h0000FC03, 32'h00004100);
        vecs[11] = mk(0, 5'd0,  32'h0,        32'h0,        0, 0, 5'd0,  32'h0,        1, 6'h00, 0, 5'd13, 32'h00000030, 32'h00004100);
        vecs[12] = mk(1, 5'd12, 32'h00000400, 32'h0,        0, 0, 5'd0,  32'h0,        0, 6'h00, 0, 5'd12, 32'h00000400, 32'h00004100);
        vecs[13] = mk(0, 5'd0,  32'h0,        32'h0,        0, 0, 5'd0,  32'h0,        0, 6'h3F, 0, 5'd13, 32'h0000FC30, 32'h00004100);
        vecs[14] = mk(1, 5'd12, 32'h0000FC01, 32'h0,        0, 0, 5'd0,  32'h0,        0, 6'h00, 0, 5'd12, 32'h0000FC01, 32'h00004100);
        vecs[15] = mk(1, 5'd14, 32'h12345678, 32'h0,        0, 0, 5'd0,  32'h0,        0, 6'h00, 0, 5'd14, 32'h12345678, 32'h12345678);
        vecs[16] = mk(0, 5'd0,  32'h0,        32'h0,        0, 0, 5'd0,  32'h0,        0, 6'h00, 0, 5'd15, 32'h00005043, 32'h12345678);
        vecs[17] = mk(1, 5'd8,  32'hFFFFFFFF, 32'h0,        0, 0, 5'd0,  32'h0,        0, 6'h00, 0, 5'd8,  32'h00001003, 32'h12345678);
        vecs[18] = mk(1, 5'd13, 32'hFFFFFFFF, 32'h0,        0, 0, 5'd0,  32'h0,        0, 6'h00, 0, 5'd13, 32'h00000030, 32'h12345678);
        vecs[19] = mk(1, 5'd3,  32'hFFFFFFFF, 32'h0,        0, 0, 5'd0,  32'h0,        0, 6'h00, 0, 5'd3,  32'h00000000, 32'h12345678);

        // Reset state, read while reset is still held
        repeat (2) @(posedge clk);
        #1;
        read_chk("rst_sr",    5'd12, 32'h0000FC01);
        read_chk("rst_cause", 5'd13, 32'h00000000);
        read_chk("rst_prid",  5'd15, 32'h00005043);
        read_chk("rst_count", 5'd9,  32'h00000000);
        chk("rst_epc",   bus.epc,       32'h0);
        chk("rst_ti",    {31'd0, bus.timer_irq}, 32'h0);
        chk("rst_take",  {31'd0, bus.exc_take},  32'h0);

        // Vector table; reset released together with the first vector so the
        // Compare write lands on the first edge where Count == Compare == 0.
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            reset            = 1'b0;
            bus.we           = vecs[i].we;
            bus.wr_addr      = vecs[i].wr_addr;
            bus.wr_data      = vecs[i].wr_data;
            bus.pc           = vecs[i].pc;
            bus.bd           = vecs[i].bd;
            bus.exc_valid    = vecs[i].exc_valid;
            bus.exc_code_in  = vecs[i].code;
            bus.bad_vaddr_in = vecs[i].badv;
            bus.eret         = vecs[i].eret;
            bus.hwint        = vecs[i].hwint;
            bus.rd_addr      = vecs[i].chk_addr;
            #1;
            chk($sformatf("v%0d_take", i), {31'd0, bus.exc_take}, {31'd0, vecs[i].exp_take});
            @(posedge clk); #1;
            clear_inputs();
            #1;
            chk($sformatf("v%0d_rd%0d", i, vecs[i].chk_addr), bus.rd_data, vecs[i].exp_rd);
            chk($sformatf("v%0d_epc", i), bus.epc, vecs[i].exp_epc);
        end

        // Timer: Compare = 1, Count = 0xFFFFFFFE, wrap through zero
        cycle_wr(1'b1, 5'd11, 32'h00000001);
        read_chk("tm_cmp", 5'd11, 32'h00000001);
        cycle_wr(1'b1, 5'd9, 32'hFFFFFFFE);
        read_chk("tm_cnt0", 5'd9, 32'hFFFFFFFE);
        cycle_wr(1'b0, 5'd0, 32'h0);
        read_chk("tm_cnt1", 5'd9, 32'hFFFFFFFF);
        cycle_wr(1'b0, 5'd0, 32'h0);
        read_chk("tm_wrap", 5'd9, 32'h00000000);
        cycle_wr(1'b0, 5'd0, 32'h0);
        read_chk("tm_cnt3", 5'd9, 32'h00000001);
        chk("tm_ti_before", {31'd0, bus.timer_irq}, 32'h0);
        cycle_wr(1'b0, 5'd0, 32'h0);
        chk("tm_ti_set",   {31'd0, bus.timer_irq}, 32'h1);
        chk("tm_take",     {31'd0, bus.exc_take},  32'h1);
        read_chk("tm_cause_ti", 5'd13, 32'h40000030);

        // Take the timer interrupt: IP15 now sampled, ExcCode 0
        @(negedge clk);
        bus.pc = 32'h00006000;
        @(posedge clk); #1;
        clear_inputs();
        read_chk("tm_cause_ip", 5'd13, 32'h40008000);
        chk("tm_epc",        bus.epc, 32'h00006000);
        chk("tm_take_exl",   {31'd0, bus.exc_take}, 32'h0);

        // Compare write clears TI on the following edge
        cycle_wr(1'b1, 5'd11, 32'hFFFF0000);
        chk("tm_ti_clr", {31'd0, bus.timer_irq}, 32'h0);
        read_chk("tm_cause_clr", 5'd13, 32'h00008000);

        // Mid-run reset beats concurrent mtc0 / exception / eret
        @(negedge clk);
        reset = 1'b1;
        bus.we = 1'b1; bus.wr_addr = 5'd12; bus.wr_data = 32'h0;
        bus.exc_valid = 1'b1; bus.exc_code_in = 5'd4;
        bus.bad_vaddr_in = 32'h0000FFFF; bus.pc = 32'h7000; bus.eret = 1'b1;
        @(posedge clk); #1;
        clear_inputs();
        read_chk("mr_sr",    5'd12, 32'h0000FC01);
        read_chk("mr_cause", 5'd13, 32'h00000000);
        read_chk("mr_badv",  5'd8,  32'h00000000);
        read_chk("mr_count", 5'd9,  32'h00000000);
        read_chk("mr_cmp",   5'd11, 32'h00000000);
        chk("mr_epc", bus.epc, 32'h0);
        chk("mr_ti",  {31'd0, bus.timer_irq}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
